// File: rtl/mips_pkg.sv
// Shared opcode constants and write classification for the writeback stage.
package mips_pkg;

  localparam logic [5:0] OP_WR0  = 6'b101000;
  localparam logic [5:0] OP_LOAD = 6'b110010;
  localparam logic [5:0] OP_WR2  = 6'b111011;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True for every opcode that produces a register-file write.
  function automatic logic writes_reg(input logic [5:0] op);
    return (op == OP_WR0) || (op == OP_LOAD) || (op == OP_WR2);
  endfunction

endpackage

// File: rtl/wb_bypass.sv
// Bypass selector for one decode read port: the write in flight beats the
// one-entry history, and r0 never hits.
module wb_bypass
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_fire,
  input  logic [REG_AW-1:0] i_wr_num,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_hist_valid,
  input  logic [REG_AW-1:0] i_hist_reg,
  input  logic [DATA_W-1:0] i_hist_data,
  input  logic [REG_AW-1:0] i_rd_num,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  // Priority select: current write, then history, else no hit.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    o_hit  = 1'b0;
    o_data = '0;
    if (i_rd_num != REG_AW'(REG_ZERO)) begin
      if (i_fire && (i_wr_num == i_rd_num)) begin
        o_hit  = 1'b1;
        o_data = i_wr_data;
      end else if (i_hist_valid && (i_hist_reg == i_rd_num)) begin
        o_hit  = 1'b1;
        o_data = i_hist_data;
      end
    end
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and register-file write driver. Issues one write
// per instruction even across stalls, keeps a one-entry write history for
// decode bypass, and counts retired instructions.
module mem_wb_writeback
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_instruction,
  input  logic [REG_AW-1:0] in_dest_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [REG_AW-1:0] rd_num_a,
  input  logic [REG_AW-1:0] rd_num_b,
  output logic              RegWrite,
  output logic [REG_AW-1:0] Write_Reg_Num,
  output logic [DATA_W-1:0] Write_Data,
  output logic              fwd_hit_a,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [CNT_W-1:0]  retired
);

  // Stage registers
  logic              r_valid;
  logic              r_done;
  logic [5:0]        r_op;
  logic [REG_AW-1:0] r_dest;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_mem;

  // Write history and retire counter
  logic              r_hist_valid;
  logic [REG_AW-1:0] r_hist_reg;
  logic [DATA_W-1:0] r_hist_data;
  logic [CNT_W-1:0]  r_retired;

  logic              w_retire;
  logic              w_fire;
  logic              w_is_load;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_unused_instr;

  // Only the opcode field travels past MEM.
  assign w_unused_instr = ^in_instruction[25:0];

  // An instruction retires (and possibly writes) only in its first WB cycle.
  assign w_retire  = r_valid & ~r_done;
  assign w_fire    = w_retire & writes_reg(r_op) & (r_dest != REG_AW'(REG_ZERO));
  assign w_is_load = (r_op == OP_LOAD);
  assign w_wr_data = w_is_load ? r_mem : r_alu;

  assign RegWrite      = w_fire;
  assign Write_Reg_Num = r_dest;
  assign Write_Data    = w_wr_data;
  assign retired       = r_retired;

  // Stage update with priority reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= '0;
      r_dest  <= '0;
      r_alu   <= '0;
      r_mem   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (stall) begin
      r_done  <= r_done | w_retire;
    end else begin
      r_valid <= in_valid;
      r_done  <= 1'b0;
      r_op    <= in_instruction[31:26];
      r_dest  <= in_dest_reg;
      r_alu   <= in_alu_result;
      r_mem   <= in_mem_data;
    end
  end

  // History remembers the most recent issued write; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist_valid <= 1'b0;
      r_hist_reg   <= '0;
      r_hist_data  <= '0;
    end else if (w_fire) begin
      r_hist_valid <= 1'b1;
      r_hist_reg   <= r_dest;
      r_hist_data  <= w_wr_data;
    end
  end

  // Saturating count of retired instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_retire && (r_retired != {CNT_W{1'b1}})) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  wb_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_a (
    .i_fire       (w_fire),
    .i_wr_num     (r_dest),
    .i_wr_data    (w_wr_data),
    .i_hist_valid (r_hist_valid),
    .i_hist_reg   (r_hist_reg),
    .i_hist_data  (r_hist_data),
    .i_rd_num     (rd_num_a),
    .o_hit        (fwd_hit_a),
    .o_data       (fwd_data_a)
  );

  wb_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_b (
    .i_fire       (w_fire),
    .i_wr_num     (r_dest),
    .i_wr_data    (w_wr_data),
    .i_hist_valid (r_hist_valid),
    .i_hist_reg   (r_hist_reg),
    .i_hist_data  (r_hist_data),
    .i_rd_num     (rd_num_b),
    .o_hit        (fwd_hit_b),
    .o_data       (fwd_data_b)
  );

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Testbench for mem_wb_writeback: a directed cycle table followed by random
// traffic compared against a transaction-level model of the stage.
module tb_mem_wb_writeback;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_instruction;
  logic [4:0]  in_dest_reg, rd_num_a, rd_num_b;
  logic [31:0] in_alu_result, in_mem_data;

  logic        RegWrite, fwd_hit_a, fwd_hit_b;
  logic [4:0]  Write_Reg_Num;
  logic [31:0] Write_Data, fwd_data_a, fwd_data_b, retired;

  // Small-counter instance shares stimulus; used for saturation.
  logic        unused_sat_rw, unused_sat_ha, unused_sat_hb;
  logic [4:0]  unused_sat_num;
  logic [31:0] unused_sat_wd, unused_sat_da, unused_sat_db;
  logic [2:0]  sat_retired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_wb_writeback #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_instruction(in_instruction),
    .in_dest_reg(in_dest_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .rd_num_a(rd_num_a), .rd_num_b(rd_num_b),
    .RegWrite(RegWrite), .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data),
    .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b), .retired(retired)
  );

  mem_wb_writeback #(.DATA_W(32), .REG_AW(5), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_instruction(in_instruction),
    .in_dest_reg(in_dest_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .rd_num_a(rd_num_a), .rd_num_b(rd_num_b),
    .RegWrite(unused_sat_rw), .Write_Reg_Num(unused_sat_num), .Write_Data(unused_sat_wd),
    .fwd_hit_a(unused_sat_ha), .fwd_data_a(unused_sat_da),
    .fwd_hit_b(unused_sat_hb), .fwd_data_b(unused_sat_db), .retired(sat_retired)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          rst, stl, fls, vld;
    logic [5:0]  op;
    logic [4:0]  dst;
    logic [31:0] alu, mem;
    logic [4:0]  ra, rb;
    bit          e_rw;
    logic [4:0]  e_num;
    logic [31:0] e_data;
    bit          e_ha;
    logic [31:0] e_da;
    bit          e_hb;
    logic [31:0] e_db;
    int          e_ret;
    bit          chk_port;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input bit rst, stl, fls, vld, input logic [5:0] op,
                     input logic [4:0] dst, input logic [31:0] alu, mem,
                     input logic [4:0] ra, rb, input bit e_rw, input logic [4:0] e_num,
                     input logic [31:0] e_data, input bit e_ha, input logic [31:0] e_da,
                     input bit e_hb, input logic [31:0] e_db, input int e_ret,
                     input bit chk_port);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fls = fls; v.vld = vld; v.op = op; v.dst = dst;
    v.alu = alu; v.mem = mem; v.ra = ra; v.rb = rb; v.e_rw = e_rw; v.e_num = e_num;
    v.e_data = e_data; v.e_ha = e_ha; v.e_da = e_da; v.e_hb = e_hb; v.e_db = e_db;
    v.e_ret = e_ret; v.chk_port = chk_port;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit rst, stl, fls, vld, input logic [5:0] op,
                       input logic [4:0] dst, input logic [31:0] alu, mem,
                       input logic [4:0] ra, rb);
    reset = rst; stall = stl; flush = fls; in_valid = vld;
    in_instruction = {op, 26'h2A5_5A5A};
    in_dest_reg = dst; in_alu_result = alu; in_mem_data = mem;
    rd_num_a = ra; rd_num_b = rb;
  endtask

  // ---------------- reference model ----------------
  // The instruction sitting in WB, whether it has already been handled,
  // whether its fields are defined, the last issued write, and a count.
  bit          m_valid, m_handled, m_known;
  logic [5:0]  m_op;
  logic [4:0]  m_dest;
  logic [31:0] m_alu, m_mem;
  bit          m_hv;
  logic [4:0]  m_hr;
  logic [31:0] m_hd;
  longint      m_count;

  function automatic bit m_writes();
    return m_valid && !m_handled && (m_op inside {OP_WR0, OP_LOAD, OP_WR2}) && (m_dest != 0);
  endfunction

  function automatic logic [31:0] m_data();
    return (m_op == OP_LOAD) ? m_mem : m_alu;
  endfunction

  task automatic m_bypass(input logic [4:0] rd, output bit hit, output logic [31:0] d);
    hit = 0; d = 0;
    if (rd != 0) begin
      if (m_writes() && m_dest == rd) begin hit = 1; d = m_data(); end
      else if (m_hv && m_hr == rd) begin hit = 1; d = m_hd; end
    end
  endtask

  task automatic m_step();
    bit retiring;
    if (reset) begin
      m_valid = 0; m_handled = 0; m_known = 1; m_op = 0; m_dest = 0;
      m_alu = 0; m_mem = 0; m_hv = 0; m_hr = 0; m_hd = 0; m_count = 0;
    end else begin
      retiring = m_valid && !m_handled;
      if (retiring) m_count++;
      if (m_writes()) begin m_hv = 1; m_hr = m_dest; m_hd = m_data(); end
      if (flush) begin
        m_valid = 0; m_handled = 0; m_known = 0;
      end else if (stall) begin
        m_handled = m_handled || retiring;
      end else begin
        m_valid = in_valid; m_handled = 0; m_known = 1;
        m_op = in_instruction[31:26]; m_dest = in_dest_reg;
        m_alu = in_alu_result; m_mem = in_mem_data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          hit;
    logic [31:0] d;
    longint      sat;

    //  rst stl fls vld op       dst    alu          mem          ra  rb   rw num  data          ha da            hb db            ret port
    row(0, 0, 0, 1, OP_WR0,  5'd5,  32'h1234,    32'h0,       0,  0,   0, 0,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
    row(0, 0, 0, 1, OP_LOAD, 5'd7,  32'h1,       32'hDEADBEEF,5,  0,   1, 5,  32'h1234,     1, 32'h1234,     0, 32'h0,        0, 1);
    row(0, 0, 0, 1, OP_WR2,  5'd3,  32'h33,      32'h44,      7,  5,   1, 7,  32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'h1234,     1, 1);
    row(0, 1, 0, 1, OP_WR0,  5'd9,  32'h99,      32'h0,       3,  7,   1, 3,  32'h33,       1, 32'h33,       1, 32'hDEADBEEF, 2, 1);
    row(0, 1, 0, 1, OP_WR0,  5'd9,  32'h99,      32'h0,       3,  7,   0, 3,  32'h33,       1, 32'h33,       0, 32'h0,        3, 1);
    row(0, 1, 0, 1, OP_WR0,  5'd9,  32'h99,      32'h0,       3,  7,   0, 3,  32'h33,       1, 32'h33,       0, 32'h0,        3, 1);
    row(0, 0, 0, 1, OP_WR0,  5'd9,  32'hA,       32'h0,       9,  3,   0, 3,  32'h33,       0, 32'h0,        1, 32'h33,       3, 1);
    row(0, 0, 0, 1, OP_WR0,  5'd9,  32'hB,       32'h0,       9,  0,   1, 9,  32'hA,        1, 32'hA,        0, 32'h0,        3, 1);
    row(0, 0, 0, 0, 6'd0,    5'd0,  32'h0,       32'h0,       9,  0,   1, 9,  32'hB,        1, 32'hB,        0, 32'h0,        4, 1);
    row(0, 0, 0, 1, OP_WR0,  5'd0,  32'h77,      32'h0,       9,  0,   0, 0,  32'h0,        1, 32'hB,        0, 32'h0,        5, 1);
    row(0, 0, 0, 1, OP_WR2,  5'd12, 32'hC,       32'h0,       0,  0,   0, 0,  32'h77,       0, 32'h0,        0, 32'h0,        5, 1);
    row(0, 1, 1, 1, OP_WR0,  5'd13, 32'hD,       32'h0,       12, 9,   1, 12, 32'hC,        1, 32'hC,        1, 32'hB,        6, 1);
    row(0, 0, 0, 1, OP_WR0,  5'd13, 32'hD,       32'h0,       12, 13,  0, 0,  32'h0,        1, 32'hC,        0, 32'h0,        7, 0);
    row(0, 1, 0, 1, OP_WR0,  5'd14, 32'hE,       32'h0,       13, 12,  1, 13, 32'hD,        1, 32'hD,        1, 32'hC,        7, 1);
    row(1, 1, 0, 1, OP_WR0,  5'd14, 32'hE,       32'h0,       13, 0,   0, 13, 32'hD,        1, 32'hD,        0, 32'h0,        8, 1);
    row(0, 1, 0, 1, OP_WR0,  5'd14, 32'hE,       32'h0,       13, 13,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
    row(0, 0, 0, 0, 6'd0,    5'd0,  32'h0,       32'h0,       13, 13,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1);

    // Initial reset
    drive(1, 0, 0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    m_step(); tick();
    m_step(); tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].fls, vecs[i].vld, vecs[i].op,
            vecs[i].dst, vecs[i].alu, vecs[i].mem, vecs[i].ra, vecs[i].rb);
      #1;
      check($sformatf("row%0d RegWrite", i), 64'(RegWrite), 64'(vecs[i].e_rw));
      if (vecs[i].chk_port) begin
        check($sformatf("row%0d Write_Reg_Num", i), 64'(Write_Reg_Num), 64'(vecs[i].e_num));
        check($sformatf("row%0d Write_Data", i), 64'(Write_Data), 64'(vecs[i].e_data));
      end
      check($sformatf("row%0d fwd_hit_a", i), 64'(fwd_hit_a), 64'(vecs[i].e_ha));
      check($sformatf("row%0d fwd_data_a", i), 64'(fwd_data_a), 64'(vecs[i].e_da));
      check($sformatf("row%0d fwd_hit_b", i), 64'(fwd_hit_b), 64'(vecs[i].e_hb));
      check($sformatf("row%0d fwd_data_b", i), 64'(fwd_data_b), 64'(vecs[i].e_db));
      check($sformatf("row%0d retired", i), 64'(retired), 64'(vecs[i].e_ret));
      check($sformatf("row%0d sat_retired", i), 64'(sat_retired),
            64'((vecs[i].e_ret > 7) ? 7 : vecs[i].e_ret));
      m_step();
      tick();
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] op;
      case ($urandom_range(0, 3))
        0: op = OP_WR0;
        1: op = OP_LOAD;
        2: op = OP_WR2;
        default: op = 6'($urandom);
      endcase
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 4) != 0), op,
            5'($urandom_range(0, 3)), $urandom, $urandom,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      #1;
      check("rand RegWrite", 64'(RegWrite), 64'(m_writes()));
      if (m_known) begin
        check("rand Write_Reg_Num", 64'(Write_Reg_Num), 64'(m_dest));
        check("rand Write_Data", 64'(Write_Data), 64'(m_data()));
      end
      m_bypass(rd_num_a, hit, d);
      check("rand fwd_hit_a", 64'(fwd_hit_a), 64'(hit));
      check("rand fwd_data_a", 64'(fwd_data_a), 64'(d));
      m_bypass(rd_num_b, hit, d);
      check("rand fwd_hit_b", 64'(fwd_hit_b), 64'(hit));
      check("rand fwd_data_b", 64'(fwd_data_b), 64'(d));
      check("rand retired", 64'(retired), 64'(m_count));
      sat = (m_count > 7) ? 7 : m_count;
      check("rand sat_retired", 64'(sat_retired), 64'(sat));
      m_step();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register plus writeback driver. It is the producer side of the register-file write port: it generates RegWrite, Write_Reg_Num and Write_Data.
- Captures the MEM-stage result, selects ALU result or load data, and fires exactly one register write per instruction.
- Holds a one-entry write history and supplies bypass data to decode, which covers the window where a read precedes write visibility.
- Maintains a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- stall  in  1  hold stage contents
- flush  in  1  kill stage contents
- in_valid  in  1  MEM stage holds a real instruction
- in_instruction  in  32  instruction word; opcode = [31:26]
- in_dest_reg  in  REG_AW  destination register number
- in_alu_result  in  DATA_W  ALU result from MEM
- in_mem_data  in  DATA_W  load data from MEM
- rd_num_a  in  REG_AW  decode read port A register number
- rd_num_b  in  REG_AW  decode read port B register number
- RegWrite  out  1  register-file write enable
- Write_Reg_Num  out  REG_AW  write address
- Write_Data  out  DATA_W  write data
- fwd_hit_a  out  1  bypass valid, port A
- fwd_data_a  out  DATA_W  bypass data, port A
- fwd_hit_b  out  1  bypass valid, port B
- fwd_data_b  out  DATA_W  bypass data, port B
- retired  out  CNT_W  instructions retired since reset

Behaviour:
- **Stage registers:** wb_valid, wb_op[5:0], wb_dest, wb_alu, wb_mem, wb_done.
- **Priority on each posedge:** reset > flush > stall > capture.
  - reset: all stage, history and counter registers go to 0.
  - flush: wb_valid=0, wb_done=0; other fields are don't-care.
  - stall: all stage registers hold, except wb_done, which is set to 1 if a write or retire fired this cycle.
  - capture: load all in_* fields; wb_valid=in_valid; wb_done=0.
- **Write classification:**
  - writes_reg = opcode in {101000, 110010, 111011}.
  - is_load = (opcode == 110010).
- **Fire condition:** fire = wb_valid & ~wb_done & writes_reg & (wb_dest != 0).
- **Write port (combinational from stage registers):**
  - RegWrite = fire.
  - Write_Reg_Num = wb_dest.
  - Write_Data = is_load ? wb_mem : wb_alu.
- **Latency:** 1 cycle from capture to RegWrite.
- **Single write under stall:** a stalled instruction writes only in its first WB cycle; wb_done suppresses repeats.
- **r0:** writes to r0 are never issued. The instruction still retires.
- **Retire counter:** increments when wb_valid & ~wb_done. This includes non-writing opcodes and r0 destinations. It saturates at all-ones.
- **History register** (hist_valid, hist_reg, hist_data):
  - Loads {1, Write_Reg_Num, Write_Data} on any cycle with fire.
  - Otherwise holds.
  - Cleared by reset only; flush does not clear it.
- **Bypass, port A** (port B identical with rd_num_b):
  - Current hit: fire & Write_Reg_Num == rd_num_a → fwd_data_a = Write_Data.
  - Else history hit: hist_valid & hist_reg == rd_num_a → fwd_data_a = hist_data.
  - Else fwd_hit_a = 0 and fwd_data_a = 0.
  - rd_num_a == 0 always gives no hit.
  - The current write takes priority over history.
- **Reset values of outputs:** RegWrite=0, Write_Reg_Num=0, Write_Data=0, fwd_hit_*=0, fwd_data_*=0, retired=0.
- **Boundary conditions:**
  - flush and stall together: flush wins.
  - reset mid-stall: stage emptied and no write next cycle.
  - Back-to-back writes to the same register: history shows the older one; the current write overrides it on bypass.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_WR0=6'b101000, OP_LOAD=6'b110010, OP_WR2=6'b111011;
  - function writes_reg(op);
  - REG_ZERO=5'd0.
- One sub-module, wb_bypass: pure comparator/mux, instantiated twice (port A and port B).

Test Plan:
- Capture in_valid=1, op=101000, dest=5, alu=0x1234 → next cycle RegWrite=1, Write_Reg_Num=5, Write_Data=0x1234; retired=1.
- op=110010, dest=7, mem=0xDEADBEEF, alu=0x1 → Write_Data=0xDEADBEEF.
- Capture op=111011 dest=3, then stall 3 cycles → RegWrite high only in cycle 1; retired increments once.
- Back-to-back writes r9=0xA then r9=0xB with rd_num_a=9 → cycle 2: fwd_data_a=0xB (current). Cycle 3 (no write): fwd_data_a=0xB (history).
- dest=0 with op=101000 → RegWrite=0, retired increments; rd_num_b=0 → fwd_hit_b=0.
- flush and stall asserted together with valid write pending → next cycle RegWrite=0. Reset pulse mid-stream → all outputs 0 and retired=0.
